// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared full-adder cell, LSB first, carry recirculated via a FF.
// Optional SERIAL_ADD_OVF_EN adds a registered signed-overflow flag (Ovf).
module fulladder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             Ovf
`endif
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] op_a, op_b, psum, psum_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_cout;
    logic             last;

    fulladder u_fa (
        .A    (op_a[0]),
        .B    (op_b[0]),
        .Cin  (carry),
        .S    (fa_s),
        .Cout (fa_cout)
    );

    // New sum bit enters at the MSB so after WIDTH shifts the LSB lands at bit 0.
    generate
        if (WIDTH == 1) begin : g_psum1
            assign psum_nxt = fa_s;
        end else begin : g_psumn
            assign psum_nxt = {fa_s, psum[WIDTH-1:1]};
        end
    endgenerate

    assign last = (cnt == LAST);
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            S     <= '0;
            Cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            Ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_a  <= A;
                    op_b  <= B;
                    carry <= Cin;
                    cnt   <= '0;
                end
                RUN: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    psum  <= psum_nxt;
                    carry <= fa_cout;
                    cnt   <= cnt + CW'(1);
                    // Results are published only on completion, never partially.
                    if (last) begin
                        S    <= psum_nxt;
                        Cout <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
                        Ovf  <= carry ^ fa_cout;
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized/exhaustive check of serial_add_ctrl at WIDTH 8, 4 and 1 against an arithmetic model.
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start8 = 0, cin8 = 0, busy8, done8, cout8;
    logic [7:0] a8 = 0, b8 = 0, s8;
    logic       start4 = 0, cin4 = 0, busy4, done4, cout4;
    logic [3:0] a4 = 0, b4 = 0, s4;
    logic       start1 = 0, cin1 = 0, busy1, done1, cout1;
    logic [0:0] a1 = 0, b1 = 0, s1;
`ifdef SERIAL_ADD_OVF_EN
    logic ovf8, ovf4, ovf1;
`endif

    serial_add_ctrl #(.WIDTH(8)) d8 (.clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
        .Cin(cin8), .busy(busy8), .done(done8), .S(s8), .Cout(cout8)
`ifdef SERIAL_ADD_OVF_EN
        , .Ovf(ovf8)
`endif
    );
    serial_add_ctrl #(.WIDTH(4)) d4 (.clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4),
        .Cin(cin4), .busy(busy4), .done(done4), .S(s4), .Cout(cout4)
`ifdef SERIAL_ADD_OVF_EN
        , .Ovf(ovf4)
`endif
    );
    serial_add_ctrl #(.WIDTH(1)) d1 (.clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1),
        .Cin(cin1), .busy(busy1), .done(done1), .S(s1), .Cout(cout1)
`ifdef SERIAL_ADD_OVF_EN
        , .Ovf(ovf1)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    time prev_done_t = 0;
    bit  chk_spacing = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(int w, logic [31:0] a, logic [31:0] b, logic c, logic st);
        case (w)
            8: begin a8 = a[7:0]; b8 = b[7:0]; cin8 = c; start8 = st; end
            4: begin a4 = a[3:0]; b4 = b[3:0]; cin4 = c; start4 = st; end
            default: begin a1 = a[0:0]; b1 = b[0:0]; cin1 = c; start1 = st; end
        endcase
    endtask

    function automatic logic [31:0] get_s(int w);
        case (w)
            8: return 32'(s8);
            4: return 32'(s4);
            default: return 32'(s1);
        endcase
    endfunction
    function automatic logic get_cout(int w);
        return (w == 8) ? cout8 : (w == 4) ? cout4 : cout1;
    endfunction
    function automatic logic get_busy(int w);
        return (w == 8) ? busy8 : (w == 4) ? busy4 : busy1;
    endfunction
    function automatic logic get_done(int w);
        return (w == 8) ? done8 : (w == 4) ? done4 : done1;
    endfunction
`ifdef SERIAL_ADD_OVF_EN
    function automatic logic get_ovf(int w);
        return (w == 8) ? ovf8 : (w == 4) ? ovf4 : ovf1;
    endfunction
`endif

    // Signed overflow: true two's-complement sum of A, B plus carry-in leaves the w-bit range.
    function automatic logic model_ovf(int w, logic [31:0] a, logic [31:0] b, logic c);
        longint sa, sb, r, lim;
        lim = longint'(1) << (w - 1);
        sa = longint'(a); sb = longint'(b);
        if (sa >= lim) sa -= 2 * lim;
        if (sb >= lim) sb -= 2 * lim;
        r = sa + sb + longint'(c);
        return (r >= lim) || (r < -lim);
    endfunction

    task automatic check_result(int w, logic [31:0] a, logic [31:0] b, logic c);
        longint sum;
        sum = longint'(a) + longint'(b) + longint'(c);
        chk("sum", 64'(get_s(w)), 64'(sum & ((longint'(1) << w) - 1)));
        chk("cout", 64'(get_cout(w)), 64'((sum >> w) & 1));
`ifdef SERIAL_ADD_OVF_EN
        chk("ovf", 64'(get_ovf(w)), 64'(model_ovf(w, a, b, c)));
`endif
    endtask

    task automatic run_op(int w, logic [31:0] a, logic [31:0] b, logic c);
        logic [31:0] prev_s;
        logic        prev_c;
        int          lat;
        prev_s = get_s(w);
        prev_c = get_cout(w);
        @(negedge clk);
        drive(w, a, b, c, 1'b1);
        @(posedge clk);
        #1;
        drive(w, $urandom, $urandom, 1'($urandom), 1'b0);
        chk("busy_run", 64'(get_busy(w)), 64'(1));
        lat = 0;
        for (int i = 1; i <= w + 4 && lat == 0; i++) begin
            @(posedge clk);
            #1;
            if (get_done(w)) lat = i;
            else if (i < w) begin
                chk("hold_s", 64'(get_s(w)), 64'(prev_s));
                chk("hold_cout", 64'(get_cout(w)), 64'(prev_c));
                chk("busy_mid", 64'(get_busy(w)), 64'(1));
            end
        end
        if (lat == 0) begin
            chk("done_timeout", 64'(0), 64'(1));
        end else begin
            chk("latency", 64'(lat), 64'(w));
            chk("busy_at_done", 64'(get_busy(w)), 64'(0));
            check_result(w, a, b, c);
            if (chk_spacing) chk("spacing", 64'(($time - prev_done_t) / 10), 64'(w + 2));
            prev_done_t = $time;
            @(posedge clk);
            #1;
            chk("done_low", 64'(get_done(w)), 64'(0));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        logic [31:0] ha, hb;
        rst_n = 1'b0;
        #12;
        chk("rst_s8", 64'(s8), 64'(0));
        chk("rst_cout8", 64'(cout8), 64'(0));
        chk("rst_busy8", 64'(busy8), 64'(0));
        chk("rst_done8", 64'(done8), 64'(0));
        chk("rst_busy4", 64'(busy4), 64'(0));
        chk("rst_busy1", 64'(busy1), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed WIDTH=8 cases
        run_op(8, 32'h5A, 32'h3C, 1'b0);
        run_op(8, 32'hFF, 32'h01, 1'b0);
        run_op(8, 32'hFF, 32'hFF, 1'b1);

        // start held through RUN, operands changing: exactly one completion
        ha = 32'h3B; hb = 32'hC7;
        @(negedge clk);
        drive(8, ha, hb, 1'b1, 1'b1);
        @(posedge clk);
        nd = 0;
        for (int i = 1; i <= 20; i++) begin
            #1;
            if (i < 9) drive(8, $urandom, $urandom, 1'($urandom), 1'b1);
            else drive(8, 0, 0, 1'b0, 1'b0);
            @(posedge clk);
            #1;
            if (done8) begin
                nd++;
                if (nd == 1) begin
                    chk("held_lat", 64'(i), 64'(8));
                    check_result(8, ha, hb, 1'b1);
                end
            end
        end
        chk("held_one_done", 64'(nd), 64'(1));
        chk("held_idle", 64'(busy8), 64'(0));

        // Async reset after 4th RUN edge
        @(negedge clk);
        drive(8, 32'h77, 32'h11, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        drive(8, 0, 0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_busy", 64'(busy8), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("arst_s", 64'(s8), 64'(0));
        chk("arst_cout", 64'(cout8), 64'(0));
        chk("arst_busy", 64'(busy8), 64'(0));
        chk("arst_done", 64'(done8), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8, 32'h01, 32'h01, 1'b0);

        // Random WIDTH=8
        for (int i = 0; i < 100; i++)
            run_op(8, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom));

        // Exhaustive WIDTH=4, back-to-back with spacing check
        run_op(4, 0, 0, 1'b0);
        chk_spacing = 1;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    run_op(4, 32'(a), 32'(b), 1'(c));
        chk_spacing = 0;

        // WIDTH=1
        run_op(1, 1, 1, 1'b1);
        for (int i = 0; i < 8; i++)
            run_op(1, $urandom_range(0, 1), $urandom_range(0, 1), 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
